// File: rtl/fb_swap_ctrl.sv
// fb_swap_ctrl -- double-buffered frame buffer controller.
// Swaps the front/back buffers on the next new-frame pulse after a CPU
// request, optionally fills the new back buffer with a colour, and forwards
// CPU pixel writes to the back buffer with one cycle of latency.
module fb_swap_ctrl #(
   parameter int FB_WIDTH  = 320,
   parameter int FB_HEIGHT = 180,
   parameter int PIXEL_W   = 24,
   parameter int ADDR_W    = 16
) (
   input  logic               clk_in,
   input  logic               rst_in,
   input  logic               nf_in,
   input  logic               swap_req_in,
   input  logic               clear_en_in,
   input  logic [PIXEL_W-1:0] clear_color_in,
   input  logic               cpu_wr_valid_in,
   input  logic [ADDR_W-1:0]  cpu_wr_addr_in,
   input  logic [PIXEL_W-1:0] cpu_wr_data_in,
   output logic               cpu_wr_ready_out,
   output logic               fb_wr_en_out,
   output logic               fb_wr_buf_out,
   output logic [ADDR_W-1:0]  fb_wr_addr_out,
   output logic [PIXEL_W-1:0] fb_wr_data_out,
   output logic               front_buf_out,
   output logic               swap_pending_out,
   output logic               busy_out,
   output logic               swap_done_out
);

   localparam int                N         = FB_WIDTH * FB_HEIGHT;
   localparam logic [ADDR_W:0]   N_EXT     = (ADDR_W+1)'(N);
   localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(N - 1);

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      PENDING = 2'd1,
      CLEAR   = 2'd2
   } state_t;

   state_t             state, state_nxt;
   logic               swap_latch;
   logic [ADDR_W-1:0]  clear_addr;
   logic [PIXEL_W-1:0] clear_color;

   // The swap happens on the cycle a new frame arrives while a swap waits.
   logic swap_now;
   logic clear_last;
   logic cpu_accept;
   logic cpu_in_range;

   assign swap_now     = (state == PENDING) && nf_in;
   assign clear_last   = (state == CLEAR) && (clear_addr == LAST_ADDR);
   assign cpu_accept   = cpu_wr_valid_in && cpu_wr_ready_out;
   assign cpu_in_range = ({1'b0, cpu_wr_addr_in} < N_EXT);

   // State register.
   // NOTE: clocked state uses non-blocking assignments so every flop samples
   // the pre-edge values regardless of block ordering.
   always_ff @(posedge clk_in or negedge rst_in) begin
      if (!rst_in) state <= IDLE;
      else         state <= state_nxt;
   end

   // Next-state decode.
   // NOTE: the default assignment first keeps this block free of latches.
   always_comb begin
      state_nxt = state;
      unique case (state)
         IDLE: begin
            if (swap_req_in) state_nxt = PENDING;
         end
         PENDING: begin
            if (nf_in) state_nxt = clear_en_in ? CLEAR : IDLE;
         end
         CLEAR: begin
            // A request arriving on the final clear cycle counts as latched.
            if (clear_last) state_nxt = (swap_latch || swap_req_in) ? PENDING : IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   // State-derived outputs; ready drops on the swap cycle so a CPU write
   // never straddles a buffer change.
   always_comb begin
      swap_pending_out = (state == PENDING);
      busy_out         = (state == CLEAR);
      cpu_wr_ready_out = rst_in && ((state == IDLE) || ((state == PENDING) && !nf_in));
   end

   // Buffer selection, swap handshake and clear bookkeeping.
   always_ff @(posedge clk_in or negedge rst_in) begin
      if (!rst_in) begin
         front_buf_out <= 1'b0;
         swap_done_out <= 1'b0;
         swap_latch    <= 1'b0;
         clear_addr    <= '0;
         clear_color   <= '0;
      end else begin
         swap_done_out <= swap_now;
         if (swap_now) begin
            front_buf_out <= ~front_buf_out;
            clear_addr    <= '0;
            if (clear_en_in) clear_color <= clear_color_in;
         end
         if (state == CLEAR) begin
            if (clear_last) begin
               clear_addr <= '0;
               swap_latch <= 1'b0;
            end else begin
               clear_addr <= clear_addr + 1'b1;
               if (swap_req_in) swap_latch <= 1'b1;
            end
         end
      end
   end

   // Registered frame buffer write port; clear writes and CPU writes are
   // exclusive because ready is low throughout CLEAR.
   always_ff @(posedge clk_in or negedge rst_in) begin
      if (!rst_in) begin
         fb_wr_en_out   <= 1'b0;
         fb_wr_buf_out  <= 1'b0;
         fb_wr_addr_out <= '0;
         fb_wr_data_out <= '0;
      end else begin
         fb_wr_en_out <= 1'b0;
         if (state == CLEAR) begin
            fb_wr_en_out   <= 1'b1;
            fb_wr_buf_out  <= ~front_buf_out;
            fb_wr_addr_out <= clear_addr;
            fb_wr_data_out <= clear_color;
         end else if (cpu_accept && cpu_in_range) begin
            fb_wr_en_out   <= 1'b1;
            fb_wr_buf_out  <= ~front_buf_out;
            fb_wr_addr_out <= cpu_wr_addr_in;
            fb_wr_data_out <= cpu_wr_data_in;
         end
      end
   end

endmodule

// File: tb/tb_fb_swap_ctrl.sv
// tb_fb_swap_ctrl -- directed self-checking bench for fb_swap_ctrl at the
// default 320x180 geometry (N = 57600).
module tb_fb_swap_ctrl;

   localparam int PIXEL_W = 24;
   localparam int ADDR_W  = 16;
   localparam int N       = 57600;

   logic               clk_in = 1'b0;
   logic               rst_in;
   logic               nf_in;
   logic               swap_req_in;
   logic               clear_en_in;
   logic [PIXEL_W-1:0] clear_color_in;
   logic               cpu_wr_valid_in;
   logic [ADDR_W-1:0]  cpu_wr_addr_in;
   logic [PIXEL_W-1:0] cpu_wr_data_in;
   logic               cpu_wr_ready_out;
   logic               fb_wr_en_out;
   logic               fb_wr_buf_out;
   logic [ADDR_W-1:0]  fb_wr_addr_out;
   logic [PIXEL_W-1:0] fb_wr_data_out;
   logic               front_buf_out;
   logic               swap_pending_out;
   logic               busy_out;
   logic               swap_done_out;

   int n_cmp = 0;
   int n_err = 0;

   fb_swap_ctrl dut (
      .clk_in           (clk_in),
      .rst_in           (rst_in),
      .nf_in            (nf_in),
      .swap_req_in      (swap_req_in),
      .clear_en_in      (clear_en_in),
      .clear_color_in   (clear_color_in),
      .cpu_wr_valid_in  (cpu_wr_valid_in),
      .cpu_wr_addr_in   (cpu_wr_addr_in),
      .cpu_wr_data_in   (cpu_wr_data_in),
      .cpu_wr_ready_out (cpu_wr_ready_out),
      .fb_wr_en_out     (fb_wr_en_out),
      .fb_wr_buf_out    (fb_wr_buf_out),
      .fb_wr_addr_out   (fb_wr_addr_out),
      .fb_wr_data_out   (fb_wr_data_out),
      .front_buf_out    (front_buf_out),
      .swap_pending_out (swap_pending_out),
      .busy_out         (busy_out),
      .swap_done_out    (swap_done_out)
   );

   always #5 clk_in = ~clk_in;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   // Advance one clock; inputs change and outputs are sampled 1 ns after the edge.
   task automatic step();
      @(posedge clk_in);
      #1;
   endtask

   initial begin
      int nwr, nbusy, errs, seen;

      rst_in          = 1'b0;
      nf_in           = 1'b0;
      swap_req_in     = 1'b0;
      clear_en_in     = 1'b0;
      clear_color_in  = '0;
      cpu_wr_valid_in = 1'b0;
      cpu_wr_addr_in  = '0;
      cpu_wr_data_in  = '0;
      step();
      step();

      // Reset state
      check("rst_front",   32'(front_buf_out),    0);
      check("rst_wr_en",   32'(fb_wr_en_out),     0);
      check("rst_wr_buf",  32'(fb_wr_buf_out),    0);
      check("rst_wr_addr", 32'(fb_wr_addr_out),   0);
      check("rst_wr_data", 32'(fb_wr_data_out),   0);
      check("rst_pending", 32'(swap_pending_out), 0);
      check("rst_busy",    32'(busy_out),         0);
      check("rst_done",    32'(swap_done_out),    0);
      check("rst_ready",   32'(cpu_wr_ready_out), 0);

      // CPU write addr 5 lands on back buffer 1 one cycle later
      rst_in = 1'b1;
      #1;
      check("idle_ready", 32'(cpu_wr_ready_out), 1);
      cpu_wr_valid_in = 1'b1;
      cpu_wr_addr_in  = 16'd5;
      cpu_wr_data_in  = 24'hFF0000;
      step();
      cpu_wr_valid_in = 1'b0;
      check("cpu_wr_en",   32'(fb_wr_en_out),   1);
      check("cpu_wr_buf",  32'(fb_wr_buf_out),  1);
      check("cpu_wr_addr", 32'(fb_wr_addr_out), 5);
      check("cpu_wr_data", 32'(fb_wr_data_out), 32'hFF0000);
      step();
      check("cpu_wr_en_off", 32'(fb_wr_en_out), 0);

      // Swap without clear, nf arrives 10 cycles after the request
      swap_req_in = 1'b1;
      step();
      swap_req_in = 1'b0;
      for (int i = 0; i < 10; i++) begin
         check("pend_hi",    32'(swap_pending_out), 1);
         check("pend_front", 32'(front_buf_out),    0);
         if (i == 9) begin
            nf_in = 1'b1;
            #1;
            check("pend_nf_ready", 32'(cpu_wr_ready_out), 0);
         end
         step();
      end
      nf_in = 1'b0;
      check("swap_front",   32'(front_buf_out),    1);
      check("swap_done",    32'(swap_done_out),    1);
      check("swap_pend_lo", 32'(swap_pending_out), 0);
      check("swap_busy_lo", 32'(busy_out),         0);
      step();
      check("swap_done_pulse", 32'(swap_done_out), 0);
      check("swap_no_clear",   32'(fb_wr_en_out),  0);
      check("swap_busy_lo2",   32'(busy_out),      0);

      // Reset pulse returns front to buffer 0
      rst_in = 1'b0;
      #1;
      check("rst2_front", 32'(front_buf_out), 0);
      step();
      rst_in = 1'b1;
      step();

      // Swap with clear, plus a swap request part-way through the clear
      swap_req_in = 1'b1;
      step();
      swap_req_in    = 1'b0;
      nf_in          = 1'b1;
      clear_en_in    = 1'b1;
      clear_color_in = 24'h123456;
      step();
      nf_in          = 1'b0;
      clear_en_in    = 1'b0;
      clear_color_in = 24'h000000;
      check("clr_front", 32'(front_buf_out), 1);
      check("clr_done",  32'(swap_done_out), 1);
      nwr   = 0;
      nbusy = 0;
      errs  = 0;
      seen  = 0;
      for (int cyc = 0; cyc < 60000; cyc++) begin
         if (busy_out) begin
            nbusy++;
            if (cpu_wr_ready_out) errs++;
         end
         if (fb_wr_en_out) begin
            if (fb_wr_buf_out !== 1'b0 || 32'(fb_wr_addr_out) != nwr ||
                fb_wr_data_out !== 24'h123456) errs++;
            nwr++;
         end
         if (!busy_out && !fb_wr_en_out) begin
            seen = 1;
            break;
         end
         swap_req_in     = (cyc == 1000);
         cpu_wr_valid_in = (cyc >= 10 && cyc < 20);
         cpu_wr_addr_in  = 16'd7;
         cpu_wr_data_in  = 24'hABCDEF;
         step();
      end
      swap_req_in     = 1'b0;
      cpu_wr_valid_in = 1'b0;
      check("clr_finished",  32'(seen),  1);
      check("clr_writes",    32'(nwr),   32'(N));
      check("clr_busy_cyc",  32'(nbusy), 32'(N));
      check("clr_errors",    32'(errs),  0);
      check("clr_to_pend",   32'(swap_pending_out), 1);
      nf_in = 1'b1;
      step();
      nf_in = 1'b0;
      check("latched_front", 32'(front_buf_out),    0);
      check("latched_done",  32'(swap_done_out),    1);
      check("latched_idle",  32'(swap_pending_out), 0);
      check("latched_ready", 32'(cpu_wr_ready_out), 1);

      // Request and nf in the same IDLE cycle: no swap yet
      swap_req_in = 1'b1;
      nf_in       = 1'b1;
      step();
      swap_req_in = 1'b0;
      nf_in       = 1'b0;
      check("same_pend",  32'(swap_pending_out), 1);
      check("same_front", 32'(front_buf_out),    0);
      check("same_done",  32'(swap_done_out),    0);
      step();
      nf_in = 1'b1;
      step();
      nf_in = 1'b0;
      check("late_front", 32'(front_buf_out), 1);
      check("late_done",  32'(swap_done_out), 1);

      // Out-of-range CPU write is consumed, last valid address is written
      cpu_wr_valid_in = 1'b1;
      cpu_wr_addr_in  = 16'd57600;
      cpu_wr_data_in  = 24'h00FF00;
      #1;
      check("oor_ready", 32'(cpu_wr_ready_out), 1);
      step();
      check("oor_no_wr", 32'(fb_wr_en_out), 0);
      cpu_wr_addr_in = 16'd57599;
      step();
      cpu_wr_valid_in = 1'b0;
      check("last_wr_en",   32'(fb_wr_en_out),   1);
      check("last_wr_addr", 32'(fb_wr_addr_out), 57599);
      check("last_wr_buf",  32'(fb_wr_buf_out),  0);

      // Reset in the middle of a clear, at clear address 100
      swap_req_in = 1'b1;
      step();
      swap_req_in = 1'b0;
      nf_in       = 1'b1;
      clear_en_in = 1'b1;
      clear_color_in = 24'h0000FF;
      step();
      nf_in       = 1'b0;
      clear_en_in = 1'b0;
      seen = 0;
      for (int cyc = 0; cyc < 500; cyc++) begin
         if (fb_wr_en_out && fb_wr_addr_out == 16'd100) begin
            seen = 1;
            break;
         end
         step();
      end
      check("abort_reached", 32'(seen), 1);
      rst_in = 1'b0;
      #1;
      check("abort_wr_en", 32'(fb_wr_en_out),     0);
      check("abort_busy",  32'(busy_out),         0);
      check("abort_ready", 32'(cpu_wr_ready_out), 0);
      step();
      rst_in = 1'b1;
      #1;
      check("post_front", 32'(front_buf_out),    0);
      check("post_ready", 32'(cpu_wr_ready_out), 1);
      check("post_pend",  32'(swap_pending_out), 0);
      nwr = 0;
      for (int cyc = 0; cyc < 5; cyc++) begin
         step();
         if (fb_wr_en_out || busy_out) nwr++;
      end
      check("post_no_wr", 32'(nwr), 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/fb_swap_ctrl.md
FB_SWAP_CTRL -- requirements
Module: fb_swap_ctrl

Interface
REQ-001 SHALL provide parameter FB_WIDTH, default 320, meaning frame buffer pixels per line.
REQ-002 SHALL provide parameter FB_HEIGHT, default 180, meaning frame buffer lines.
REQ-003 SHALL provide parameter PIXEL_W, default 24, meaning pixel data width ({red,green,blue}, 8 bits each).
REQ-004 SHALL provide parameter ADDR_W, default 16, meaning pixel address width; N = FB_WIDTH*FB_HEIGHT SHALL be at most 2^ADDR_W.
REQ-005 clk_in  input  1  pixel clock; all logic on its rising edge.
REQ-006 rst_in  input  1  reset, asynchronous assert, active-low.
REQ-007 nf_in  input  1  one-cycle new-frame pulse from the video signal generator, same clock domain.
REQ-008 swap_req_in  input  1  one-cycle CPU request to swap front/back buffers.
REQ-009 clear_en_in  input  1  when high at swap time, clear the new back buffer after the swap.
REQ-010 clear_color_in  input  PIXEL_W  fill value for the clear.
REQ-011 cpu_wr_valid_in  input  1  CPU pixel write request.
REQ-012 cpu_wr_addr_in  input  ADDR_W  CPU pixel address (y*FB_WIDTH+x).
REQ-013 cpu_wr_data_in  input  PIXEL_W  CPU pixel value.
REQ-014 cpu_wr_ready_out  output  1  CPU write accepted when valid and ready are both high.
REQ-015 fb_wr_en_out  output  1  frame buffer write strobe.
REQ-016 fb_wr_buf_out  output  1  buffer index targeted by the write.
REQ-017 fb_wr_addr_out  output  ADDR_W  write address.
REQ-018 fb_wr_data_out  output  PIXEL_W  write data.
REQ-019 front_buf_out  output  1  buffer index the HDMI read path displays.
REQ-020 swap_pending_out  output  1  high while a swap waits for nf_in.
REQ-021 busy_out  output  1  high while a clear is in progress.
REQ-022 swap_done_out  output  1  one-cycle pulse in the cycle after the swap takes effect.

Function
REQ-023 SHALL implement FSM states IDLE, PENDING and CLEAR; the back buffer is always ~front_buf_out.
REQ-024 IDLE: swap_req_in -> PENDING next cycle; an nf_in in the same cycle SHALL NOT perform the swap.
REQ-025 PENDING: swap_req_in ignored; on nf_in, front_buf_out toggles and swap_done_out pulses the next cycle; next state CLEAR (clear address 0) if clear_en_in is high that cycle, else IDLE.
REQ-026 CLEAR: one write per cycle of clear_color_in (sampled at swap) to the back buffer, addresses 0..N-1 ascending; after address N-1 the FSM leaves CLEAR; busy_out is high for exactly N cycles.
REQ-027 swap_req_in during CLEAR SHALL be latched; on clear completion the next state is PENDING if latched, else IDLE; the latch clears on that exit.
REQ-028 cpu_wr_ready_out SHALL be combinational: high in IDLE, and in PENDING except the cycle nf_in is high; low in CLEAR and while rst_in is low.
REQ-029 An accepted CPU write SHALL appear on fb_wr_* exactly 1 cycle later, to the back buffer as of the acceptance cycle.
REQ-030 An accepted CPU write with cpu_wr_addr_in >= N SHALL be consumed and dropped (fb_wr_en_out stays low).
REQ-031 fb_wr_* SHALL be registered; fb_wr_en_out is low whenever no CPU or clear write is issued; CPU and clear writes never coincide.
REQ-032 swap_pending_out SHALL be high exactly while the state is PENDING.

Reset
REQ-033 While rst_in is low: state IDLE, front_buf_out=0, fb_wr_en_out=0, fb_wr_buf_out=0, fb_wr_addr_out=0, fb_wr_data_out=0, swap_pending_out=0, busy_out=0, swap_done_out=0, swap latch cleared, clear address 0.
REQ-034 Reset asserted mid-CLEAR or mid-PENDING SHALL abort the operation with no further writes; after release the FSM is IDLE.

Verification
REQ-035 Reset release, CPU write addr 5 data 0xFF0000 -> next cycle fb_wr_en_out=1, buf=1, addr=5, data 0xFF0000.
REQ-036 swap_req_in, clear_en_in=0, nf_in 10 cycles later -> swap_pending_out high for 10 cycles, front_buf_out 0->1, swap_done_out one pulse, no clear writes.
REQ-037 Swap with clear_en_in=1, color 0x123456 -> exactly 57600 writes to buffer 0, addr 0..57599; busy_out high 57600 cycles; cpu_wr_ready_out low throughout.
REQ-038 swap_req_in during CLEAR -> after address 57599 the FSM enters PENDING; next nf_in toggles front_buf_out back to 0.
REQ-039 swap_req_in and nf_in in the same IDLE cycle -> no swap; swap on the following nf_in; CPU write addr 57600 -> accepted, no fb write.
REQ-040 rst_in low at clear address 100 -> fb_wr_en_out low immediately; after release state IDLE, front_buf_out=0, ready high.
